// File: rtl/crop_norm_pkg.sv
// Shared types and width helpers for the crop/normalise path.
package crop_norm_pkg;

  typedef enum logic [2:0] {IDLE, CAPTURE, RECIP, EMIT, DONE} state_t;
  typedef enum logic {NORM_MAX, NORM_MINMAX} mode_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned prod_w(input int unsigned pix_w, input int unsigned out_w,
                                         input int unsigned frac_w);
    return pix_w + out_w + frac_w;
  endfunction

endpackage

// File: rtl/crop_norm_minmax_recip_divider.sv
// Restoring divider producing ceil(K*2^FRAC_W / den); den = 0 yields 0.
module recip_divider
  import crop_norm_pkg::*;
#(
  parameter int unsigned DEN_W  = 8,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned FRAC_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DEN_W-1:0]          den,
  output logic                      busy,
  output logic                      done,
  output logic [OUT_W+FRAC_W-1:0]   recip
);
  localparam int unsigned QW    = OUT_W + FRAC_W;
  localparam int unsigned CNT_W = cnt_w(QW);

  logic [DEN_W-1:0] den_m1;
  logic [QW:0]      numer;
  logic [QW-1:0]    num, q;
  logic [DEN_W-1:0] rem, den_q;
  logic [CNT_W-1:0] cnt;
  logic             zero;
  logic [DEN_W:0]   trial, diff;
  logic             ge;
  logic             unused_ok;

  assign den_m1 = den - DEN_W'(1);
  assign numer  = {1'b0, {OUT_W{1'b1}}, {FRAC_W{1'b0}}} + (QW+1)'(den_m1);

  // The quotient always fits in QW bits, so the numerator MSB is pre-loaded
  // into the remainder and only QW iterations are needed.
  assign trial = {rem, num[QW-1]};
  assign ge    = trial >= {1'b0, den_q};
  assign diff  = trial - {1'b0, den_q};
  assign recip = zero ? '0 : q;
  assign unused_ok = diff[DEN_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num   <= '0;
      q     <= '0;
      rem   <= '0;
      den_q <= '0;
      cnt   <= '0;
      zero  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        num   <= numer[QW-1:0];
        rem   <= DEN_W'(numer[QW]);
        q     <= '0;
        den_q <= den;
        zero  <= (den == '0);
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        num <= {num[QW-2:0], 1'b0};
        q   <= {q[QW-2:0], ge};
        rem <= ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
        if (cnt == CNT_W'(QW - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/crop_norm_minmax.sv
// Frame capture, crop-window buffering and max / min-max normalised streaming.
module crop_norm_minmax
  import crop_norm_pkg::*;
#(
  parameter int unsigned IN_ROWS  = 20,
  parameter int unsigned IN_COLS  = 20,
  parameter int unsigned OUT_ROWS = 10,
  parameter int unsigned OUT_COLS = 10,
  parameter int unsigned PIXEL_W  = 8,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned FRAC_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ap_start,
  output logic                        ap_ready,
  output logic                        ap_done,
  output logic                        ap_idle,
  input  logic                        norm_mode,
  input  logic [$clog2(IN_COLS)-1:0]  crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0]  crop_y0,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [PIXEL_W-1:0]          s_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [OUT_W-1:0]            m_axis_tdata,
  output logic                        m_axis_tlast
);
  localparam int unsigned CW   = $clog2(IN_COLS);
  localparam int unsigned RW   = $clog2(IN_ROWS);
  localparam int unsigned NPIX = OUT_ROWS * OUT_COLS;
  localparam int unsigned AW   = cnt_w(NPIX);
  localparam int unsigned QW   = OUT_W + FRAC_W;
  localparam int unsigned PW   = prod_w(PIXEL_W, OUT_W, FRAC_W);
  localparam logic [CW-1:0]    X_MAX = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0]    Y_MAX = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [OUT_W-1:0] K     = '1;

  state_t state, state_n;
  mode_t  mode;

  logic [CW-1:0]      x0, col;
  logic [RW-1:0]      y0, row;
  logic [CW:0]        col_rel;
  logic [RW:0]        row_rel;
  logic               in_win, last_in, s_hs, m_hs, adv, issue;
  logic [PIXEL_W-1:0] pmax, pmin, den, off, rd_data;
  logic [AW-1:0]      wr_addr;
  logic [AW:0]        rd_cnt;
  logic               div_go, div_done, div_busy;
  logic [QW-1:0]      div_q, recip;
  logic               v1, v2, l1, l2;
  logic [PW-1:0]      prod;
  logic [PIXEL_W+OUT_W-1:0] scaled;
  logic [OUT_W-1:0]   sat;
  logic               unused_ok;
  logic [PIXEL_W-1:0] mem [NPIX];

  assign col_rel = {1'b0, col} - {1'b0, x0};
  assign row_rel = {1'b0, row} - {1'b0, y0};
  assign in_win  = (col >= x0) && (col_rel < (CW+1)'(OUT_COLS)) &&
                   (row >= y0) && (row_rel < (RW+1)'(OUT_ROWS));
  assign last_in = (row == RW'(IN_ROWS - 1)) && (col == CW'(IN_COLS - 1));
  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign m_hs    = m_axis_tvalid && m_axis_tready;
  assign adv     = !m_axis_tvalid || m_axis_tready;
  assign issue   = (state == EMIT) && (rd_cnt != (AW+1)'(NPIX));
  assign den     = (mode == NORM_MINMAX) ? pmax - pmin : pmax;
  assign off     = rd_data - ((mode == NORM_MINMAX) ? pmin : '0);
  assign scaled  = prod[PW-1:FRAC_W];
  assign sat     = (scaled > (PIXEL_W+OUT_W)'(K)) ? K : scaled[OUT_W-1:0];
  assign unused_ok = ^{prod[FRAC_W-1:0], div_busy};

  recip_divider #(
    .DEN_W  (PIXEL_W),
    .OUT_W  (OUT_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_go),
    .den   (den),
    .busy  (div_busy),
    .done  (div_done),
    .recip (div_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    ap_ready      = 1'b0;
    ap_idle       = 1'b0;
    ap_done       = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state)
      IDLE: begin
        ap_ready = 1'b1;
        ap_idle  = 1'b1;
        if (ap_start) state_n = CAPTURE;
      end
      CAPTURE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && last_in) state_n = RECIP;
      end
      RECIP:   if (div_done) state_n = EMIT;
      EMIT:    if (m_hs && m_axis_tlast) state_n = DONE;
      DONE: begin
        ap_done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Window buffer: pixels arrive in raster order, so window addresses are sequential.
  always_ff @(posedge clk) begin
    if (s_hs && in_win) mem[wr_addr] <= s_axis_tdata;
    if (adv && issue)   rd_data <= mem[rd_cnt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode          <= NORM_MAX;
      x0            <= '0;
      y0            <= '0;
      row           <= '0;
      col           <= '0;
      wr_addr       <= '0;
      rd_cnt        <= '0;
      pmax          <= '0;
      pmin          <= '1;
      div_go        <= 1'b0;
      recip         <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      l1            <= 1'b0;
      l2            <= 1'b0;
      prod          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      div_go <= 1'b0;
      if (state == IDLE && ap_start) begin
        mode    <= norm_mode ? NORM_MINMAX : NORM_MAX;
        x0      <= (crop_x0 > X_MAX) ? X_MAX : crop_x0;
        y0      <= (crop_y0 > Y_MAX) ? Y_MAX : crop_y0;
        row     <= '0;
        col     <= '0;
        wr_addr <= '0;
        rd_cnt  <= '0;
        pmax    <= '0;
        pmin    <= '1;
      end
      if (s_hs) begin
        if (col == CW'(IN_COLS - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (in_win) begin
          wr_addr <= wr_addr + 1'b1;
          if (s_axis_tdata > pmax) pmax <= s_axis_tdata;
          if (s_axis_tdata < pmin) pmin <= s_axis_tdata;
        end
        if (last_in) div_go <= 1'b1;
      end
      if (div_done) recip <= div_q;
      // Read, multiply and output stages all stall together under backpressure.
      if (adv) begin
        v1 <= issue;
        l1 <= issue && (rd_cnt == (AW+1)'(NPIX - 1));
        if (issue) rd_cnt <= rd_cnt + 1'b1;
        v2   <= v1;
        l2   <= l1;
        prod <= PW'(off) * PW'(recip);
        m_axis_tvalid <= v2;
        m_axis_tlast  <= l2;
        if (v2) m_axis_tdata <= sat;
      end
    end
  end

endmodule

// File: tb/tb_crop_norm_minmax.sv
// Directed bench for crop_norm_minmax on an 8x8 frame with a 4x4 window.
module tb_crop_norm_minmax;
  localparam int unsigned IR = 8, IC = 8, WR = 4, WC = 4;

  logic       clk, reset, ap_start, ap_ready, ap_done, ap_idle, norm_mode;
  logic [2:0] crop_x0, crop_y0;
  logic       s_axis_tvalid, s_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0] m_axis_tdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] frame [IR*IC];
  logic [7:0] got_d [$];
  bit         got_l [$];
  logic [7:0] ref_d [$];

  crop_norm_minmax #(
    .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(WR), .OUT_COLS(WC),
    .PIXEL_W(8), .OUT_W(8), .FRAC_W(16)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .norm_mode(norm_mode),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned exp_pix(input int unsigned pix, input int unsigned mn,
                                          input int unsigned mx, input bit mm);
    longint unsigned d, rc, v;
    d = mm ? mx - mn : mx;
    if (d == 0) return 0;
    rc = (64'd255 * 64'd65536 + d - 1) / d;
    v  = (longint'(pix - (mm ? mn : 0)) * rc) >> 16;
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic start_frame(input bit mm, input logic [2:0] x0, input logic [2:0] y0);
    int budget = 500;
    @(negedge clk);
    while (!ap_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("start_timeout", 0, 1);
    norm_mode = mm; crop_x0 = x0; crop_y0 = y0; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
  endtask

  task automatic feed(input bit gaps);
    int i = 0;
    int budget = 2000;
    while (i < IR*IC && budget > 0) begin
      @(negedge clk);
      budget--;
      if (gaps && $urandom_range(0, 3) == 0) s_axis_tvalid = 1'b0;
      else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = frame[i];
      end
      if (s_axis_tvalid && s_axis_tready) i++;
    end
    if (budget == 0) check("feed_timeout", i, IR*IC);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic collect(input int n, input bit stall);
    int budget = 2000;
    int done_seen = 0;
    bit prev_stall = 0;
    logic [7:0] prev_d = '0;
    logic prev_l = 0;
    got_d.delete();
    got_l.delete();
    while (got_d.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, prev_d);
        check("stall_last", m_axis_tlast, prev_l);
      end
      if (ap_done) done_seen++;
      m_axis_tready = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
    end
    if (budget == 0) check("collect_timeout", got_d.size(), n);
    if (n == WR*WC) begin
      @(negedge clk);
      m_axis_tready = 1'b0;
      check("done_pulse", ap_done, 1);
      @(negedge clk);
      check("done_clear", ap_done, 0);
      check("idle_after", ap_idle, 1);
      check("done_early", done_seen, 0);
    end
  endtask

  task automatic check_all(input string tag, input bit mm, input int x0, input int y0);
    int unsigned mn = 255, mx = 0, p;
    check({tag, "_count"}, got_d.size(), WR*WC);
    for (int k = 0; k < WR*WC; k++) begin
      p = frame[(y0 + k / WC) * IC + x0 + k % WC];
      if (p < mn) mn = p;
      if (p > mx) mx = p;
    end
    for (int k = 0; k < WR*WC; k++) begin
      if (k < got_d.size()) begin
        p = frame[(y0 + k / WC) * IC + x0 + k % WC];
        check($sformatf("%s_pix%0d", tag, k), got_d[k], exp_pix(p, mn, mx, mm));
        check($sformatf("%s_last%0d", tag, k), got_l[k], (k == WR*WC - 1));
      end
    end
  endtask

  task automatic geom_frame();
    for (int r = 0; r < IR; r++)
      for (int c = 0; c < IC; c++) frame[r*IC + c] = 8'(8*r + c);
  endtask

  initial begin
    reset = 1'b0; ap_start = 1'b0; norm_mode = 1'b0; crop_x0 = '0; crop_y0 = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", ap_ready, 1);
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_sready", s_axis_tready, 0);
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_mlast", m_axis_tlast, 0);
    check("rst_mdata", m_axis_tdata, 0);
    reset = 1'b1;

    // Geometry: window rows 3..6, cols 2..5, max 53
    geom_frame();
    start_frame(1'b0, 3'd2, 3'd3); feed(1'b0); collect(WR*WC, 1'b0);
    check("geom_recip", dut.recip, 315315);
    check("geom_first", got_d[0], 125);
    check("geom_lastv", got_d[WR*WC-1], 255);
    check_all("geom", 1'b0, 2, 3);
    ref_d = got_d;

    // Max mode: alternating 100/200 window, zeros elsewhere
    foreach (frame[i]) frame[i] = 8'd0;
    for (int k = 0; k < WR*WC; k++) frame[(k / WC) * IC + k % WC] = (k % 2) ? 8'd200 : 8'd100;
    start_frame(1'b0, 3'd0, 3'd0); feed(1'b0); collect(WR*WC, 1'b0);
    check("max_recip", dut.recip, 83559);
    check("max_100", got_d[0], 127);
    check("max_200", got_d[1], 255);
    check_all("max", 1'b0, 0, 0);

    // Min-max: 50/150/250 then 150, extremes outside window must be ignored
    foreach (frame[i]) frame[i] = (i % 2) ? 8'd0 : 8'd255;
    for (int k = 0; k < WR*WC; k++) frame[(2 + k / WC) * IC + 2 + k % WC] = 8'd150;
    frame[2*IC + 2] = 8'd50;
    frame[2*IC + 4] = 8'd250;
    start_frame(1'b1, 3'd2, 3'd2); feed(1'b0); collect(WR*WC, 1'b0);
    check("mm_50", got_d[0], 0);
    check("mm_150", got_d[1], 127);
    check("mm_250", got_d[2], 255);
    check_all("mm", 1'b1, 2, 2);

    // Flat frame in min-max mode: zero span
    foreach (frame[i]) frame[i] = 8'd77;
    start_frame(1'b1, 3'd1, 3'd1); feed(1'b0); collect(WR*WC, 1'b0);
    for (int k = 0; k < WR*WC; k++) check($sformatf("flat_%0d", k), got_d[k], 0);

    // Clamping: x0=y0=7 land on 4, window max 63
    geom_frame();
    start_frame(1'b0, 3'd7, 3'd7); feed(1'b0); collect(WR*WC, 1'b0);
    check("clamp_first", got_d[0], 145);
    check("clamp_lastv", got_d[WR*WC-1], 255);
    check_all("clamp", 1'b0, 4, 4);

    // All-zero frame in max mode
    foreach (frame[i]) frame[i] = 8'd0;
    start_frame(1'b0, 3'd0, 3'd0); feed(1'b0); collect(WR*WC, 1'b0);
    for (int k = 0; k < WR*WC; k++) check($sformatf("zero_%0d", k), got_d[k], 0);

    // Backpressure and input gaps must reproduce the geometry run
    geom_frame();
    start_frame(1'b0, 3'd2, 3'd3); feed(1'b1); collect(WR*WC, 1'b1);
    check("bp_count", got_d.size(), WR*WC);
    for (int k = 0; k < WR*WC; k++)
      if (k < got_d.size()) check($sformatf("bp_pix%0d", k), got_d[k], ref_d[k]);

    // Reset after five outputs, then a clean frame
    start_frame(1'b0, 3'd2, 3'd3); feed(1'b0); collect(5, 1'b0);
    check("mid_n", got_d.size(), 5);
    @(negedge clk);
    m_axis_tready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_mvalid", m_axis_tvalid, 0);
    check("mid_mdata", m_axis_tdata, 0);
    check("mid_mlast", m_axis_tlast, 0);
    check("mid_idle", ap_idle, 1);
    @(negedge clk);
    reset = 1'b1;
    start_frame(1'b0, 3'd2, 3'd3); feed(1'b0); collect(WR*WC, 1'b0);
    check_all("after_rst", 1'b0, 2, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crop_norm_minmax.md
# crop_norm_minmax

Parametrised successor to the two-stage crop/normalise path. It consumes one full frame of PIXEL_W-bit pixels from the frame-grabber sequentializer and generates its own row/column counters. It buffers the OUT_ROWS×OUT_COLS crop window on chip, then streams it out scaled to OUT_W bits in one of two run-time modes: max-normalisation, or min-max normalisation (new). It replaces the crop_filter/norm_reader pair between the sequentializer and the downstream inference stream.

## Interface
- IN_ROWS, 20: input frame rows
- IN_COLS, 20: input frame columns
- OUT_ROWS, 10: crop window rows, ≤ IN_ROWS
- OUT_COLS, 10: crop window columns, ≤ IN_COLS
- PIXEL_W, 8: input pixel width
- OUT_W, 8: output pixel width; full scale K = 2^OUT_W−1
- FRAC_W, 16: reciprocal fraction bits

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- ap_start  in  1  frame request; honoured only while ap_ready=1
- ap_ready  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse after the last output handshake
- ap_idle  out  1  high in IDLE
- norm_mode  in  1  0 = max, 1 = min-max; latched on ap_start
- crop_x0  in  $clog2(IN_COLS)  window left column; latched on ap_start
- crop_y0  in  $clog2(IN_ROWS)  window top row; latched on ap_start
- s_axis_tvalid  in  1, s_axis_tready  out  1, s_axis_tdata  in  PIXEL_W  raster-order input
- m_axis_tvalid  out  1, m_axis_tready  in  1, m_axis_tdata  out  OUT_W  normalised output
- m_axis_tlast  out  1  high on the final window pixel

## Operation
- Reset: state IDLE; ap_ready=1, ap_idle=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- IDLE → CAPTURE on ap_start.
  - Latch norm_mode and crop coordinates.
  - Clamp crop_x0 to min(crop_x0, IN_COLS−OUT_COLS) and crop_y0 likewise to IN_ROWS−OUT_ROWS.
- CAPTURE:
  - s_axis_tready=1.
  - Each handshake advances col, wrapping into row.
  - In-window pixels are written to the buffer at (row−y0)·OUT_COLS+(col−x0), and update running max and min. max resets to 0, min to all-ones.
  - After IN_ROWS·IN_COLS handshakes → RECIP. s_axis_tready drops the same cycle.
- RECIP:
  - den = max (mode 0) or max−min (mode 1).
  - Restoring divider computes recip = ceil(K·2^FRAC_W / den) in exactly OUT_W+FRAC_W cycles.
  - den=0 gives recip=0.
  - → EMIT.
- EMIT:
  - Read the buffer in address order.
  - off = pix − (mode ? min : 0).
  - out = min(K, (off·recip) >> FRAC_W). The product width is PIXEL_W+OUT_W+FRAC_W.
  - After the last output handshake → DONE.
- DONE: one cycle with ap_done=1 → IDLE.
- ap_start outside IDLE is ignored.
- An asynchronous reset assertion in any state returns the block to IDLE immediately. The partial frame is discarded and buffer contents are don't-care.

## Timing
- Buffer read latency 1 cycle, followed by one multiply register and one output register.
- The first m_axis_tvalid occurs ≤3 cycles after EMIT entry.
- With m_axis_tready held at 1, the block emits one pixel per cycle.
- Backpressure:
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
  - No pixel is dropped or duplicated.
  - The pipeline stalls or uses a 2-entry skid.
- Input stalls (s_axis_tvalid=0) freeze the counters. There is no timeout.
- Minimum frame period: IN_ROWS·IN_COLS + OUT_W+FRAC_W + OUT_ROWS·OUT_COLS + 4 cycles.

## Structure
- Package crop_norm_pkg: state enum {IDLE, CAPTURE, RECIP, EMIT, DONE}; mode enum {NORM_MAX, NORM_MINMAX}; localparam widths (counter, address, product).
- Sub-module recip_divider: start/busy/done restoring divider. Ceiling is obtained by adding den−1 to the numerator; den=0 is special-cased.
- Window buffer: inferred simple dual-port RAM, OUT_ROWS·OUT_COLS × PIXEL_W.

## Test plan
- **Geometry.** IN 8×8, OUT 4×4, x0=2, y0=3, pixel = 8r+c, mode 0.
  - Max = 53, recip = 315315.
  - First output 125, last output 255 with tlast, 16 outputs total.
  - ap_done pulses once after the 16th handshake.
- **Max mode.** Window of 100/200 pixels, defaults.
  - recip = 83559; 100→127, 200→255.
- **Min-max mode.** Window pixels 50, 150, 250.
  - Outputs 0, 127, 255.
  - Flat frame of all 77 → every output 0.
- **Clamping/zero.** crop_x0 = IN_COLS−1 → window starts at IN_COLS−OUT_COLS. An all-zero frame in mode 0 → all outputs 0.
- **Backpressure.** m_axis_tready random at 30% duty plus gaps in s_axis_tvalid.
  - Output sequence is identical to the no-stall run.
  - Data is stable while stalled.
- **Reset mid-EMIT.** Assert reset after 5 outputs.
  - Outputs go to reset values asynchronously.
  - A new ap_start then produces a complete, correct frame.
